// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - two-port fixed-priority front end for a single-port synchronous RAM
module ram_access_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int MAX_WAIT      = 7
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]    p0_wdata,
  output logic                     p0_gnt,
  output logic                     p0_rvalid,
  output logic [DATA_WIDTH-1:0]    p0_rdata,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]    p1_wdata,
  output logic                     p1_gnt,
  output logic                     p1_rvalid,
  output logic [DATA_WIDTH-1:0]    p1_rdata,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       force1;
  logic       tag_valid;
  logic       tag_port;

  // Port 1 wins only when port 0 is idle or it has been starved long enough.
  assign force1 = (wait_cnt == MAX_W);
  assign p1_gnt = reset_n & p1_req & (force1 | ~p0_req);
  assign p0_gnt = reset_n & p0_req & ~p1_gnt;

  assign p0_rdata = ram_dataOut;
  assign p1_rdata = ram_dataOut;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt   <= '0;
      ram_wEn    <= 1'b0;
      ram_addr   <= '0;
      ram_dataIn <= '0;
      tag_valid  <= 1'b0;
      tag_port   <= 1'b0;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
    end else begin
      if (p1_gnt || !p1_req)
        wait_cnt <= '0;
      else if (wait_cnt != MAX_W)
        wait_cnt <= wait_cnt + 4'd1;

      if (p0_gnt) begin
        ram_wEn    <= p0_we;
        ram_addr   <= p0_addr;
        ram_dataIn <= p0_wdata;
        tag_valid  <= ~p0_we;
        tag_port   <= 1'b0;
      end else if (p1_gnt) begin
        ram_wEn    <= p1_we;
        ram_addr   <= p1_addr;
        ram_dataIn <= p1_wdata;
        tag_valid  <= ~p1_we;
        tag_port   <= 1'b1;
      end else begin
        // Address is left alone so the RAM just re-reads the same word.
        ram_wEn   <= 1'b0;
        tag_valid <= 1'b0;
      end

      p0_rvalid <= tag_valid & ~tag_port;
      p1_rvalid <= tag_valid & tag_port;
    end
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Two-port front end that shares one single-port synchronous RAM between port 0 (processor data memory) and port 1 (game/VGA logic reading sprite and score data).
- Port 0 has fixed priority. A starvation counter forces a port 1 grant after MAX_WAIT consecutive denials.
- Drives the RAM's clk/wEn/addr/dataIn inputs through registers and returns read data to the requester with a fixed 2-cycle latency.

Parameters:
DATA_WIDTH, 32, data bus width; must match the RAM.
ADDRESS_WIDTH, 12, address width; must match the RAM.
MAX_WAIT, 7, consecutive port 1 denials before port 1 is forced to win; legal range 0..15.

Ports:
clk  input  1  system clock; also the RAM clock.
reset_n  input  1  synchronous active-low reset.
p0_req  input  1  port 0 access request.
p0_we  input  1  port 0 write (1) / read (0).
p0_addr  input  ADDRESS_WIDTH  port 0 address.
p0_wdata  input  DATA_WIDTH  port 0 write data.
p0_gnt  output  1  port 0 request accepted this cycle (combinational).
p0_rvalid  output  1  port 0 read data valid (registered pulse).
p0_rdata  output  DATA_WIDTH  port 0 read data.
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: identical for port 1.
ram_wEn  output  1  to RAM wEn.
ram_addr  output  ADDRESS_WIDTH  to RAM addr.
ram_dataIn  output  DATA_WIDTH  to RAM dataIn.
ram_dataOut  input  DATA_WIDTH  from RAM dataOut.

Behaviour:
- Interface: single clock clk; reset is synchronous and active-low on reset_n. Everything updates on posedge clk only.
- Reset (reset_n=0 at a posedge):
  - ram_wEn=0, ram_addr=0, ram_dataIn=0.
  - p0_rvalid=p1_rvalid=0; internal read-pending tags cleared; wait_cnt=0.
  - p0_gnt=p1_gnt=0 while reset_n=0.
- Grant (combinational, at most one grant per cycle):
  - force1 = (wait_cnt == MAX_WAIT).
  - p1_gnt = p1_req & (force1 | ~p0_req).
  - p0_gnt = p0_req & ~p1_gnt.
  - A requester holds req/we/addr/wdata stable until it sees gnt. Its transaction is taken at the edge where gnt=1.
- Starvation counter:
  - wait_cnt increments when p1_req & ~p1_gnt, saturating at MAX_WAIT.
  - Clears when p1_gnt or ~p1_req.
  - MAX_WAIT=0 gives port 1 strict priority.
- Issue stage (edge E, granted port g):
  - ram_wEn <= g.we; ram_addr <= g.addr; ram_dataIn <= g.wdata.
  - Read-pending tag <= {valid = ~g.we, port = g}.
- With no grant:
  - ram_wEn <= 0, ram_dataIn unchanged.
  - ram_addr unchanged, so the RAM re-reads harmlessly; the tag is cleared.
- RAM stage: the RAM acts at edge E+1 (write, or dataOut update on read).
- Response:
  - At edge E+1, px_rvalid <= tag.valid & (tag.port == x); the tag advances to a second pipeline register.
  - px_rdata = ram_dataOut, driven combinationally. It is valid only while px_rvalid=1.
  - Read latency: gnt at cycle E-1 -> rvalid high in cycle E+1 (2 clocks).
  - rvalid is a single-cycle pulse per read.
- Writes produce no rvalid. Write completes at edge E+1.
- Back-to-back:
  - A new grant is allowed every cycle. Issue and response pipelines overlap, sustaining 1 access/cycle.
  - Read-after-write to the same address issued on consecutive grants returns the new data, because the RAM write lands one edge before the read.
- Reset mid-operation: in-flight tags are dropped. No rvalid is produced for reads granted before reset; pending writes not yet issued to RAM are lost.
- Idle: no req on either port -> no RAM write ever occurs (ram_wEn stays 0).

Test Plan:
- Reset: reset_n=0 for 2 cycles with both req=1 -> all gnt/rvalid=0, ram_wEn=0, ram_addr=0, wait_cnt=0.
- Port 0 write then read: p0 write addr 0x010 data 0xDEADBEEF, next cycle p0 read 0x010 -> p0_rvalid pulses 2 cycles after read grant with p0_rdata=0xDEADBEEF; p1_rvalid stays 0.
- Priority: both request reads (p0 addr 0x001, p1 addr 0x002) in the same cycle -> p0_gnt=1, p1_gnt=0; p1 is granted the next cycle; rvalids arrive in order p0 then p1, one cycle apart.
- Starvation, MAX_WAIT=7: p0_req held high continuously, p1_req high -> p1 denied 7 cycles, p1_gnt=1 on the 8th, wait_cnt returns to 0, p0 is granted again the following cycle.
- Throughput: p1 issues 16 consecutive reads of 0x100..0x10F preloaded with the index value -> 16 rvalid pulses on consecutive cycles, rdata 0..15 in order.
- Reset mid-flight: grant a p0 read, assert reset_n=0 the next cycle -> no p0_rvalid ever appears; after release a fresh read completes normally.
